// File: rtl/top.sv
// SIMD array processor: LENGTH PEs, each with a 32x16 register file, all running one broadcast instruction per start edge.
// Optional feature macro: TOP_MUL_EN enables opcode 7 (16x16 multiply, low half written); otherwise opcode 7 is a NOP.
module top #(
  parameter int SIZE   = 5,
  parameter int LENGTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic            start,
  input  logic [SIZE-1:0] PE_Addr,
  input  logic [9:0]      RegAddr,
  output logic [15:0]     data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

`ifdef TOP_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic        r_start_q;
  logic [31:0] r_instr;
  logic        w_start_edge;
  logic        w_we;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [15:0] w_pe_rdata [LENGTH];

  assign w_start_edge = start & ~r_start_q;
  assign w_op  = r_instr[31:26];
  assign w_rs  = r_instr[25:21];
  assign w_rt  = r_instr[20:16];
  assign w_rd  = r_instr[15:11];
  assign w_imm = {5'd0, r_instr[10:0]};

  // start_q tracks start every cycle, so an edge seen outside IDLE is consumed rather than queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_instr   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= start;
      if (r_state == IDLE && w_start_edge)
        r_instr <= instruction;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_state_next = DECODE;
      DECODE:  w_state_next = EXEC;
      EXEC:    w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_we = 1'b0;
    case (w_op)
      6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9: w_we = 1'b1;
      6'd7:    w_we = MUL_EN;
      default: w_we = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LENGTH; gi++) begin : g_pe
      logic [15:0] r_rf [32];
      logic [15:0] r_opa;
      logic [15:0] r_opb;
      logic [15:0] r_res;
      logic [15:0] w_alu;

      always_comb begin
        w_alu = '0;
        case (w_op)
          6'd1:    w_alu = r_opa + r_opb;
          6'd2:    w_alu = r_opa - r_opb;
          6'd3:    w_alu = r_opa & r_opb;
          6'd4:    w_alu = r_opa | r_opb;
          6'd5:    w_alu = r_opa ^ r_opb;
          6'd6:    w_alu = r_opa << r_opb[3:0];
`ifdef TOP_MUL_EN
          6'd7:    w_alu = r_opa * r_opb;
`endif
          6'd8:    w_alu = w_imm;
          6'd9:    w_alu = r_opa + w_imm;
          default: w_alu = '0;
        endcase
      end

      // Operands are captured in DECODE, so rd may alias rs/rt without hazard.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int r = 0; r < 32; r++)
            r_rf[r] <= 16'(r + gi);
          r_opa <= '0;
          r_opb <= '0;
          r_res <= '0;
        end else begin
          if (r_state == DECODE) begin
            r_opa <= r_rf[w_rs];
            r_opb <= r_rf[w_rt];
          end
          if (r_state == EXEC)
            r_res <= w_alu;
          if (r_state == WB && w_we)
            r_rf[w_rd] <= r_res;
        end
      end

      assign w_pe_rdata[gi] = r_rf[RegAddr[4:0]];
    end
  endgenerate

  // PE addresses at or beyond LENGTH and register addresses >= 32 read as zero.
  always_comb begin
    data = '0;
    for (int p = 0; p < LENGTH; p++)
      if (PE_Addr == SIZE'(p) && RegAddr[9:5] == 5'd0)
        data = w_pe_rdata[p];
  end

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for top, built with LENGTH=30 so PE addresses 30 and 31 are out of range.
module tb_top;
  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        start;
  logic [4:0]  PE_Addr;
  logic [9:0]  RegAddr;
  logic [15:0] data;

  int total = 0;
  int bad   = 0;

  top #(.SIZE(5), .LENGTH(30)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .start(start),
    .PE_Addr(PE_Addr), .RegAddr(RegAddr), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] ADD_R1   = 32'h04210800;  // rd1 = r1 + r1
  localparam logic [31:0] MUL_R3   = 32'h1C241800;  // rd3 = r1 * r4
  localparam logic [31:0] LDI_R2   = 32'h200017FF;  // rd2 = 0x7FF
  localparam logic [31:0] ADDI_R2  = 32'h24401001;  // rd2 = r2 + 1

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%h", tag, got);
    end
  endtask

  task automatic chk_reg(input string tag, input int pe, input int ra, input logic [15:0] exp);
    PE_Addr = pe[4:0];
    RegAddr = ra[9:0];
    #1;
    check_eq(tag, data, exp);
  endtask

  // Issue one instruction and return just after edge N+3, when rd is visible.
  task automatic issue(input logic [31:0] ins);
    @(negedge clk);
    instruction = ins;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [5:0]  ops [7] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd0, 6'd12};
  logic [15:0] e0  [7] = '{16'hFFFE, 16'd4, 16'd6, 16'd2, 16'd256, 16'd256, 16'd256};
  logic [15:0] e3  [7] = '{16'hFFFE, 16'd1, 16'd15, 16'd14, 16'd3584, 16'd3584, 16'd3584};

  initial begin
    reset = 1'b0;
    start = 1'b0;
    instruction = '0;
    PE_Addr = '0;
    RegAddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    chk_reg("rst_pe17_r3", 17, 3, 16'd20);
    chk_reg("rst_pe0_r31", 0, 31, 16'd31);
    chk_reg("rst_pe29_r31", 29, 31, 16'd60);
    chk_reg("oob_reg", 0, 32, 16'd0);
    chk_reg("oob_pe31", 31, 0, 16'd0);
    chk_reg("oob_pe30", 30, 5, 16'd0);

    // MUL with latency probe at N+2 (old value) and N+3 (new value)
    @(negedge clk);
    instruction = MUL_R3;
    start = 1'b1;
    PE_Addr = 5'd17;
    RegAddr = 10'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    instruction = LDI_R2;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mul_not_yet", data, 16'd20);
    @(posedge clk);
    #1;
`ifdef TOP_MUL_EN
    check_eq("mul_pe17_r3", data, 16'd378);
    chk_reg("mul_pe0_r3", 0, 3, 16'd4);
    chk_reg("mul_pe29_r3", 29, 3, 16'd990);
`else
    check_eq("mul_pe17_r3", data, 16'd20);
    chk_reg("mul_pe0_r3", 0, 3, 16'd3);
    chk_reg("mul_pe29_r3", 29, 3, 16'd32);
`endif

    // start held high for 1000 cycles issues once
    @(negedge clk);
    instruction = ADD_R1;
    start = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk_reg("hold_pe0_r1", 0, 1, 16'd2);
    chk_reg("hold_pe5_r1", 5, 1, 16'd12);
    chk_reg("hold_pe29_r1", 29, 1, 16'd60);

    // back-to-back LDI then ADDI; instruction changes after the edge are ignored
    @(negedge clk);
    instruction = LDI_R2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    instruction = ADDI_R2;
    repeat (3) @(posedge clk);
    #1;
    chk_reg("ldi_pe0_r2", 0, 2, 16'h07FF);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    instruction = ADD_R1;
    @(negedge clk);
    start = 1'b1;  // edge sampled during EXEC must be dropped
    repeat (2) @(posedge clk);
    #1;
    chk_reg("addi_pe0_r2", 0, 2, 16'h0800);
    chk_reg("addi_pe29_r2", 29, 2, 16'h0800);
    repeat (10) @(posedge clk);
    #1;
    chk_reg("ignored_pe7_r2", 7, 2, 16'h0800);
    chk_reg("ignored_pe5_r1", 5, 1, 16'd12);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);

    // reset asserted during EXEC of an ADD
    @(negedge clk);
    instruction = ADD_R1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk_reg("inrst_pe5_r1", 5, 1, 16'd6);
    chk_reg("inrst_pe0_r2", 0, 2, 16'd2);
    chk_reg("inrst_pe17_r3", 17, 3, 16'd20);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_reg("postrst_pe5_r1", 5, 1, 16'd6);
    issue(ADD_R1);
    chk_reg("postrst_add_pe5", 5, 1, 16'd12);
    chk_reg("postrst_add_pe0", 0, 1, 16'd2);

    // ALU ops rd10 = r4 op r6, plus two NOP encodings
    for (int i = 0; i < 7; i++) begin
      issue({ops[i], 5'd4, 5'd6, 5'd10, 11'd0});
      chk_reg($sformatf("op%0d_pe0", ops[i]), 0, 10, e0[i]);
      chk_reg($sformatf("op%0d_pe3", ops[i]), 3, 10, e3[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
